// File: rtl/spi_sensor_model_pkg.sv
// Shared definitions for the SPI sensor model: command op codes, field widths
// and the fixed response words for out-of-range channel/register accesses.
package spi_sensor_pkg;

    typedef enum logic [1:0] {
        OP_CONVERT = 2'b00,
        OP_CLEAR   = 2'b01,
        OP_WRITE   = 2'b10,
        OP_READ    = 2'b11
    } op_e;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned REG_DW = 16;

    localparam logic [REG_DW-1:0] BAD_REG = 16'hDEAD;
    // All-ones; replicated to the frame width at the point of use.
    localparam logic [63:0]       BAD_CH  = '1;

endpackage

// File: rtl/spi_sensor_model_if.sv
// SPI bus between the encoder (master) and the sensor model (slave).
// sclk stays a plain port on the sensor so it can also clock the model.
interface spi_sensor_model_if;

    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output cs_n, output mosi, input  miso);
    modport slave  (input  cs_n, input  mosi, output miso);

endinterface

// File: rtl/spi_sensor_model_resp_pipe.sv
// Response pipeline: DEPTH-stage shift FIFO, pushed once per completed frame.
// The head is the response that goes out in the next frame.
module sensor_resp_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    // Shift a new response in on every push; all stages clear on reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (push_i) begin
            stage_q[0] <= din_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_sensor_model.sv
// SPI-slave model of an RHS2116-class sensor: decodes command frames, keeps
// per-channel sample counters and a register file, and answers each command
// PIPE_DEPTH frames later.
// Optional feature macro: SPI_SENSOR_FAULT_INJECT_EN adds fault_bit/fault_en
// to invert one bit of the loaded TX word.
module spi_sensor_model
    import spi_sensor_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned REG_N      = 16
) (
    input  logic                sclk,
    input  logic                rst_n,
    spi_sensor_model_if.slave   spi,
    output logic [15:0]         frame_cnt,
    output logic [DATA_W-1:0]   last_cmd,
    output logic [7:0]          abort_cnt
`ifdef SPI_SENSOR_FAULT_INJECT_EN
    ,
    input  logic [5:0]          fault_bit,
    input  logic                fault_en
`endif
);

    localparam int unsigned       CNT_W    = DATA_W - IDX_W;
    localparam int unsigned       BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    logic                cs_n;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0]    neg_cnt_q;
    logic [DATA_W-2:0]   rx_q;
    logic [DATA_W-1:0]   cmd_w;
    logic                frame_done;
    op_e                 cmd_op;
    logic [IDX_W-1:0]    cmd_idx;
    logic [REG_DW-1:0]   cmd_data;
    logic [DATA_W-1:0]   resp_d;
    logic [CNT_W-1:0]    cnt_sel;
    logic [REG_DW-1:0]   reg_sel;
    logic                ch_ok;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [REG_DW-1:0]   reg_q [REG_N];
    logic [15:0]         frame_cnt_q;
    logic [DATA_W-1:0]   last_cmd_q;
    logic [7:0]          abort_cnt_q;
    logic                abort_req_q;
    logic                abort_ack_q;
    logic [DATA_W-1:0]   pipe_head;
    logic [DATA_W-1:0]   tx_word;
    logic [DATA_W-1:0]   tx_shifted;

    assign cs_n       = spi.cs_n;
    assign cmd_w      = {rx_q, spi.mosi};
    assign frame_done = !cs_n && (bit_cnt_q == LAST_BIT);
    assign cmd_op     = op_e'(cmd_w[DATA_W-1 -: 2]);
    assign cmd_idx    = cmd_w[DATA_W-3 -: IDX_W];
    assign cmd_data   = cmd_w[REG_DW-1:0];
    assign bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_W'(1);

    // Bit counter: wraps to 0 on the completing edge, cleared while cs_n is high.
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (cs_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // MOSI shift-in; the frame's last bit is taken straight from mosi.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if (!cs_n) begin
            rx_q <= {rx_q[DATA_W-3:0], spi.mosi};
        end
    end

    // Falling-edge copy of the bit count selects the MISO bit.
    // The TX word itself is never shifted destructively, so an aborted frame
    // leaves it intact and the next frame re-sends it from the MSB.
    always_ff @(negedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            neg_cnt_q <= '0;
        end else if (cs_n) begin
            neg_cnt_q <= '0;
        end else begin
            neg_cnt_q <= bit_cnt_q;
        end
    end

    // Command decode: response word for the frame completing on this edge.
    always_comb begin
        resp_d  = '0;
        cnt_sel = '0;
        reg_sel = BAD_REG;
        ch_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cmd_idx == IDX_W'(i)) begin
                ch_ok   = 1'b1;
                cnt_sel = cnt_q[i];
            end
        end
        for (int unsigned i = 0; i < REG_N; i++) begin
            if (cmd_idx == IDX_W'(i)) begin
                reg_sel = reg_q[i];
            end
        end
        case (cmd_op)
            OP_CONVERT: resp_d = ch_ok ? {cmd_idx, cnt_sel} : {DATA_W{BAD_CH[0]}};
            OP_CLEAR:   resp_d = '0;
            OP_WRITE:   resp_d = DATA_W'(cmd_data);
            OP_READ:    resp_d = DATA_W'(reg_sel);
        endcase
    end

    // Channel counters: CONVERT bumps one channel, CLEAR zeroes them all.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (frame_done) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cmd_op == OP_CLEAR) begin
                    cnt_q[i] <= '0;
                end else if (cmd_op == OP_CONVERT && cmd_idx == IDX_W'(i)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register file: WRITE to an in-range index stores the data field.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                reg_q[i] <= '0;
            end
        end else if (frame_done && cmd_op == OP_WRITE) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                if (cmd_idx == IDX_W'(i)) begin
                    reg_q[i] <= cmd_data;
                end
            end
        end
    end

    // Frame bookkeeping: completed-frame count and last command word.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            last_cmd_q  <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            last_cmd_q  <= cmd_w;
        end
    end

    // Abort request: toggles when cs_n rises on a partial frame.
    // A toggle crosses into the sclk domain without a second writer.
    always_ff @(posedge cs_n or negedge rst_n) begin
        if (!rst_n) begin
            abort_req_q <= 1'b0;
        end else if (bit_cnt_q != '0) begin
            abort_req_q <= ~abort_req_q;
        end
    end

    // Abort counter: counts a pending request on the next rising sclk, saturating.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            abort_ack_q <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            abort_ack_q <= abort_req_q;
            if (abort_req_q != abort_ack_q && abort_cnt_q != 8'hFF) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end
    end

    sensor_resp_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (PIPE_DEPTH)
    ) u_pipe (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .push_i (frame_done),
        .din_i  (resp_d),
        .head_o (pipe_head)
    );

`ifdef SPI_SENSOR_FAULT_INJECT_EN
    logic [DATA_W-1:0] fault_mask_q;
    logic [31:0]       fault_sh;

    assign fault_sh = 32'(fault_bit) % DATA_W;

    // Fault mask: captured with the TX word load, held until the next completion.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            fault_mask_q <= '0;
        end else if (frame_done) begin
            fault_mask_q <= fault_en ? (DATA_W'(1) << fault_sh) : '0;
        end
    end

    assign tx_word = pipe_head ^ fault_mask_q;
`else
    assign tx_word = pipe_head;
`endif

    assign tx_shifted = tx_word << neg_cnt_q;
    assign spi.miso   = cs_n ? 1'b0 : tx_shifted[DATA_W-1];

    assign frame_cnt  = frame_cnt_q;
    assign last_cmd   = last_cmd_q;
    assign abort_cnt  = abort_cnt_q;

endmodule

// File: tb/tb_spi_sensor_model.sv
// Directed bench for spi_sensor_model (DATA_W=32, NUM_CH=16, PIPE_DEPTH=2,
// REG_N=16). Expected response words are hand-computed constants.
module tb_spi_sensor_model;

    localparam int unsigned DW = 32;

    localparam logic [31:0] CONV3   = 32'h0300_0000;
    localparam logic [31:0] CONV0   = 32'h0000_0000;
    localparam logic [31:0] CONV1   = 32'h0100_0000;
    localparam logic [31:0] CONV2   = 32'h0200_0000;
    localparam logic [31:0] CONV4   = 32'h0400_0000;
    localparam logic [31:0] CONV7   = 32'h0700_0000;
    localparam logic [31:0] CONV20  = 32'h1400_0000;
    localparam logic [31:0] CLEAR   = 32'h4000_0000;
    localparam logic [31:0] WR5     = 32'h8500_1234;
    localparam logic [31:0] RD5     = 32'hC500_0000;
    localparam logic [31:0] RD40    = 32'hE800_0000;

    logic           sclk;
    logic           rst_n;
    logic [15:0]    frame_cnt;
    logic [DW-1:0]  last_cmd;
    logic [7:0]     abort_cnt;
    logic [31:0]    rx;
`ifdef SPI_SENSOR_FAULT_INJECT_EN
    logic [5:0]     fault_bit;
    logic           fault_en;
`endif

    int unsigned n_cmp;
    int unsigned n_bad;

    spi_sensor_model_if spi_if ();

    spi_sensor_model #(
        .DATA_W     (DW),
        .NUM_CH     (16),
        .PIPE_DEPTH (2),
        .REG_N      (16)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .spi       (spi_if),
        .frame_cnt (frame_cnt),
        .last_cmd  (last_cmd),
        .abort_cnt (abort_cnt)
`ifdef SPI_SENSOR_FAULT_INJECT_EN
        ,
        .fault_bit (fault_bit),
        .fault_en  (fault_en)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        sclk        = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.mosi = 1'b0;
        #10 rst_n = 1'b1;
        #5;
    endtask

    // Clocks n bits of cmd out MSB first; MISO sampled mid low phase.
    task automatic shift_bits(input logic [31:0] cmd, input int n, output logic [31:0] rx_o);
        rx_o = '0;
        for (int i = 31; i >= 32 - n; i--) begin
            spi_if.mosi = cmd[i];
            #2 rx_o[i] = spi_if.miso;
            #3 sclk = 1'b1;
            #5 sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] cmd, output logic [31:0] rx_o);
        spi_if.cs_n = 1'b0;
        #5;
        shift_bits(cmd, 32, rx_o);
        #5 spi_if.cs_n = 1'b1;
        #5;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef SPI_SENSOR_FAULT_INJECT_EN
        fault_bit = 6'd0;
        fault_en  = 1'b0;
`endif

        // Reset values and pipeline latency on CONVERT ch 3
        do_reset();
        check_eq("rst_miso", {31'b0, spi_if.miso}, 32'd0);
        check_eq("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check_eq("rst_last_cmd", last_cmd, 32'd0);
        check_eq("rst_abort_cnt", {24'b0, abort_cnt}, 32'd0);
        spi_frame(CONV3, rx); check_eq("conv3_f1", rx, 32'h0000_0000);
        spi_frame(CONV3, rx); check_eq("conv3_f2", rx, 32'h0000_0000);
        spi_frame(CONV3, rx); check_eq("conv3_f3", rx, 32'h0C00_0000);
        spi_frame(CONV3, rx); check_eq("conv3_f4", rx, 32'h0C00_0001);
        check_eq("conv3_frame_cnt", {16'b0, frame_cnt}, 32'd4);
        check_eq("conv3_last_cmd", last_cmd, CONV3);

        // Register write / read-back, out-of-range read
        do_reset();
        spi_frame(WR5, rx);   check_eq("wr5_f1", rx, 32'h0000_0000);
        spi_frame(RD5, rx);   check_eq("rd5_f2", rx, 32'h0000_0000);
        spi_frame(CONV0, rx); check_eq("wr5_echo", rx, 32'h0000_1234);
        spi_frame(CONV0, rx); check_eq("rd5_data", rx, 32'h0000_1234);
        spi_frame(RD40, rx);  check_eq("conv0_cnt0", rx, 32'h0000_0000);
        spi_frame(CONV0, rx); check_eq("conv0_cnt1", rx, 32'h0000_0001);
        spi_frame(CONV0, rx); check_eq("rd40_dead", rx, 32'h0000_DEAD);

        // Out-of-range channel leaves counters alone
        do_reset();
        spi_frame(CONV20, rx);
        spi_frame(CONV4, rx);
        check_eq("cs_high_miso", {31'b0, spi_if.miso}, 32'd0);
        spi_frame(CONV4, rx); check_eq("conv20_bad", rx, 32'hFFFF_FFFF);
        spi_frame(CONV4, rx); check_eq("conv4_unchanged", rx, 32'h1000_0000);

        // Abort after 10 bits: no side effects, same TX word re-sent
        do_reset();
        spi_frame(CONV3, rx);
        spi_frame(CONV3, rx);
        spi_frame(CONV3, rx);
        spi_if.cs_n = 1'b0;
        #5;
        shift_bits(CONV7, 10, rx);
        #5 spi_if.cs_n = 1'b1;
        #5;
        check_eq("abort_frame_cnt", {16'b0, frame_cnt}, 32'd3);
        spi_frame(CONV3, rx); check_eq("abort_resend", rx, 32'h0C00_0001);
        check_eq("abort_cnt", {24'b0, abort_cnt}, 32'd1);
        check_eq("abort_frame_cnt2", {16'b0, frame_cnt}, 32'd4);
        spi_frame(CONV3, rx); check_eq("abort_next", rx, 32'h0C00_0002);

        // Reset mid-frame is not counted as an abort
        do_reset();
        spi_if.cs_n = 1'b0;
        #5;
        shift_bits(CONV3, 10, rx);
        rst_n = 1'b0;
        #5 spi_if.cs_n = 1'b1;
        #5 rst_n = 1'b1;
        #5;
        spi_frame(CONV3, rx); check_eq("rstmid_rx", rx, 32'h0000_0000);
        check_eq("rstmid_abort_cnt", {24'b0, abort_cnt}, 32'd0);
        check_eq("rstmid_frame_cnt", {16'b0, frame_cnt}, 32'd1);

        // CLEAR takes effect for the following CONVERT
        do_reset();
        spi_frame(CONV1, rx);
        spi_frame(CONV1, rx);
        spi_frame(CONV1, rx);
        spi_frame(CLEAR, rx);
        spi_frame(CONV1, rx); check_eq("pre_clear_cnt", rx, 32'h0400_0002);
        spi_frame(CONV2, rx); check_eq("clear_resp", rx, 32'h0000_0000);
        spi_frame(CONV2, rx); check_eq("post_clear_cnt", rx, 32'h0400_0000);

`ifdef SPI_SENSOR_FAULT_INJECT_EN
        // Fault injection flips bit 0 of the loaded word only while enabled
        do_reset();
        spi_frame(CONV3, rx);
        spi_frame(CONV3, rx);
        fault_en = 1'b1;
        spi_frame(CONV3, rx); check_eq("fi_pre", rx, 32'h0C00_0000);
        fault_en = 1'b0;
        spi_frame(CONV3, rx); check_eq("fi_flipped", rx, 32'h0C00_0000);
        spi_frame(CONV3, rx); check_eq("fi_exact", rx, 32'h0C00_0002);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
